mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/rv32i_mmio_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_mmio_pkg.sv
// Shared register map, STATUS bit layout and FSM encodings for the MMIO peripherals.
package rv32i_mmio_pkg;

    // Byte offsets inside the 8-byte register window (bits [1:0] are never decoded)
    localparam logic [2:0] UART_OFF_TXDATA = 3'h0;
    localparam logic [2:0] UART_OFF_STATUS = 3'h4;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    typedef struct packed {
        logic overflow;
        logic busy;
        logic empty;
        logic full;
    } uart_status_t;

    function automatic logic [31:0] uart_status_word(input uart_status_t s);
        logic [31:0] w;
        w                = '0;
        w[STAT_FULL]     = s.full;
        w[STAT_EMPTY]    = s.empty;
        w[STAT_BUSY]     = s.busy;
        w[STAT_OVERFLOW] = s.overflow;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-two transmit FIFO with show-ahead output and an occupancy count.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, FIFO and serializer FSM.
module mmio_uart_tx
    import rv32i_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    // Bus decode
    logic       hit;
    logic [2:0] offset;
    logic       hit_txdata;
    logic       hit_status;
    logic       wr_txdata;
    logic       push;
    logic       drop;
    logic       clr_ovf;
    logic       unused_bus_bits;

    assign hit             = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign offset          = {mem_addr[2], 2'b00};
    assign hit_txdata      = hit && (offset == UART_OFF_TXDATA);
    assign hit_status      = hit && (offset == UART_OFF_STATUS);
    assign unused_bus_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    // FIFO
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Acceptance looks only at the pre-edge count, so a same-edge pop never rescues a full FIFO.
    assign wr_txdata = mem_we && hit_txdata;
    assign push      = wr_txdata && (fifo_count < DEPTH_C);
    assign drop      = wr_txdata && !push;
    assign clr_ovf   = mem_we && hit_status && mem_wdata[STAT_OVERFLOW];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          overflow;
    logic          baud_done;
    logic          tx_next;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign pop = !fifo_empty &&
                 ((state == UART_ST_IDLE) || ((state == UART_ST_STOP) && baud_done));

    // NOTE: combinational outputs get a default before the case so no path leaves them unassigned.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            UART_ST_START: tx_next = 1'b0;
            UART_ST_DATA:  tx_next = shreg[bit_idx];
            default:       ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= UART_ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
            tx       <= 1'b1;
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            tx <= tx_next;

            case (state)
                UART_ST_IDLE: begin
                    if (pop) begin
                        shreg    <= fifo_dout;
                        baud_cnt <= '0;
                        state    <= UART_ST_START;
                    end
                end
                UART_ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= UART_ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                UART_ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) state <= UART_ST_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                UART_ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Back-to-back frames: reload straight into START with no idle bit
                        if (pop) begin
                            shreg <= fifo_dout;
                            state <= UART_ST_START;
                        end else begin
                            state <= UART_ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: state <= UART_ST_IDLE;
            endcase
        end
    end

    // Register read-back
    uart_status_t status;

    assign status.overflow = overflow;
    assign status.busy     = (state != UART_ST_IDLE);
    assign status.empty    = fifo_empty;
    assign status.full     = fifo_full;
    assign mem_rdata       = hit_status ? uart_status_word(status) : 32'h0;

endmodule
